// File: rtl/conv_sched_pkg.sv
// conv_pkg: shared types and defaults for the convolution scheduler.
//   - FSM state enum
//   - default image geometry and engine latency
//   - pixel / result / position widths
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam int IMG_W_DEF   = 28;
  localparam int IMG_H_DEF   = 28;
  localparam int ENG_LAT_DEF = 4;

  localparam int PIX_W  = 16;
  localparam int RES_W  = 32;
  localparam int POS_W  = 5;
  localparam int SLOT_W = 2;
  localparam int RCNT_W = 10;

endpackage

// File: rtl/conv_pos_cnt.sv
// conv_pos_cnt: input-side pixel position tracker.
//   clk, reset : clock, async active-high reset
//   clr        : restart at position (0,0,0)
//   adv        : one pixel accepted, step the position
//   row        : pixel position within the current line, 0..IMG_W-1
//   slot       : line-buffer slot, line index mod 3
//   last       : current position is the final pixel of the frame
module conv_pos_cnt
  import conv_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  output logic [POS_W-1:0]  row,
  output logic [SLOT_W-1:0] slot,
  output logic              last
);

  localparam logic [POS_W-1:0]  ROW_LAST  = POS_W'(IMG_W - 1);
  localparam logic [POS_W-1:0]  LINE_LAST = POS_W'(IMG_H - 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2);

  logic [POS_W-1:0] line;

  assign last = (row == ROW_LAST) && (line == LINE_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row  <= '0;
      slot <= '0;
      line <= '0;
    end else if (clr) begin
      row  <= '0;
      slot <= '0;
      line <= '0;
    end else if (adv) begin
      if (row == ROW_LAST) begin
        row  <= '0;
        slot <= (slot == SLOT_LAST) ? '0 : slot + SLOT_W'(1);
        line <= (line == LINE_LAST) ? '0 : line + POS_W'(1);
      end else begin
        row <= row + POS_W'(1);
      end
    end
  end

endmodule

// File: rtl/conv_sched.sv
// conv_sched: frame scheduler between a pixel source and a 3x3 conv engine.
//   clk, reset          : clock, async active-high reset
//   start, abort        : one-cycle frame control pulses
//   src_data/valid/ready: pixel stream in
//   eng_data/row/col/rdata : registered pixel + position to the engine
//   eng_result, eng_fin : engine result stream in
//   res_data/valid/x/y  : forwarded result with its output coordinates
//   busy, done, err     : frame status (err sticky until reset or start)
// Optional build macro CONV_SCHED_PERF_EN adds stall_cnt and frame_cycles.
module conv_sched
  import conv_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int ENG_LAT   = ENG_LAT_DEF,
  parameter int DRAIN_MAX = 15
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [PIX_W-1:0]  src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [PIX_W-1:0]  eng_data,
  output logic [POS_W-1:0]  eng_row,
  output logic [SLOT_W-1:0] eng_col,
  output logic              eng_rdata,
  input  logic [RES_W-1:0]  eng_result,
  input  logic              eng_fin,
  output logic [RES_W-1:0]  res_data,
  output logic              res_valid,
  output logic [POS_W-1:0]  res_x,
  output logic [POS_W-1:0]  res_y,
  output logic              busy,
  output logic              done,
  output logic              err
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       frame_cycles
`endif
);

  localparam logic [RCNT_W-1:0] RES_EXP = RCNT_W'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [POS_W-1:0]  RX_LAST = POS_W'(IMG_W - 3);
  // Drain timer has headroom for the engine pipeline on top of the window.
  localparam int                DRN_W   = $clog2(DRAIN_MAX + ENG_LAT + 2);
  localparam logic [DRN_W-1:0]  DRN_LIM = DRN_W'(DRAIN_MAX);

  state_t state, nstate;

  logic [POS_W-1:0]  row;
  logic [SLOT_W-1:0] slot;
  logic              pos_last;
  logic [POS_W-1:0]  rx, ry;
  logic [RCNT_W-1:0] res_cnt;
  logic [DRN_W-1:0]  drain_cnt;

  logic accept, last_pix, frame_go, fin_live, res_last, timeout;

  assign frame_go = (state == IDLE) && start;
  assign accept   = src_valid && src_ready;
  assign last_pix = accept && pos_last;
  // abort suppresses any result in its cycle, including the final one
  assign fin_live = eng_fin && busy && !abort && (res_cnt < RES_EXP);
  assign res_last = fin_live && (res_cnt == RES_EXP - RCNT_W'(1));
  // fires on the (DRAIN_MAX+1)-th consecutive clock without eng_fin
  assign timeout  = (state == DRAIN) && !eng_fin && !abort && (drain_cnt == DRN_LIM);

  conv_pos_cnt #(.IMG_W(IMG_W), .IMG_H(IMG_H)) u_pos (
    .clk   (clk),
    .reset (reset),
    .clr   (frame_go),
    .adv   (accept),
    .row   (row),
    .slot  (slot),
    .last  (pos_last)
  );

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nstate;
  end

  // FSM: next state
  always_comb begin
    nstate = state;
    case (state)
      IDLE:  if (start) nstate = FEED;
      FEED:  if (abort)         nstate = IDLE;
             else if (res_last) nstate = FIN;
             else if (last_pix) nstate = DRAIN;
      DRAIN: if (abort)                    nstate = IDLE;
             else if (res_last || timeout) nstate = FIN;
      FIN:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    src_ready = (state == FEED);
    busy      = (state == FEED) || (state == DRAIN);
    done      = (state == FIN);
  end

  // Engine-side pixel register: holds through stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_data  <= '0;
      eng_row   <= '0;
      eng_col   <= '0;
      eng_rdata <= 1'b0;
    end else begin
      eng_rdata <= accept;
      if (accept) begin
        eng_data <= src_data;
        eng_row  <= row;
        eng_col  <= slot;
      end
    end
  end

  // Result forwarding and output coordinates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_data  <= '0;
      res_valid <= 1'b0;
      res_x     <= '0;
      res_y     <= '0;
      rx        <= '0;
      ry        <= '0;
      res_cnt   <= '0;
    end else begin
      res_valid <= fin_live;
      if (frame_go) begin
        res_x   <= '0;
        res_y   <= '0;
        rx      <= '0;
        ry      <= '0;
        res_cnt <= '0;
      end else if (fin_live) begin
        res_data <= eng_result;
        res_x    <= rx;
        res_y    <= ry;
        res_cnt  <= res_cnt + RCNT_W'(1);
        if (rx == RX_LAST) begin
          rx <= '0;
          ry <= ry + POS_W'(1);
        end else begin
          rx <= rx + POS_W'(1);
        end
      end
    end
  end

  // Drain watchdog and sticky error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drain_cnt <= '0;
      err       <= 1'b0;
    end else begin
      if (state != DRAIN || eng_fin)  drain_cnt <= '0;
      else if (drain_cnt != DRN_LIM)  drain_cnt <= drain_cnt + DRN_W'(1);
      if (frame_go)     err <= 1'b0;
      else if (timeout) err <= 1'b1;
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt    <= '0;
      frame_cycles <= '0;
    end else if (frame_go) begin
      stall_cnt    <= '0;
      frame_cycles <= '0;
    end else begin
      if (state == FEED && !src_valid && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (state != IDLE && frame_cycles != 16'hFFFF)
        frame_cycles <= frame_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: doc/conv_sched.md
CONV_SCHED -- requirements
Module: conv_sched

Interface
REQ-001 Parameters SHALL be:
- IMG_W, default 28, image width in pixels.
- IMG_H, default 28, image height in lines.
- ENG_LAT, default 4, clocks from an accepted pixel to the engine's result strobe.
- DRAIN_MAX, default 15, maximum drain wait in clocks.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock; all logic is on the rising edge.
- reset, in, 1, asynchronous active-high reset.
- start, in, 1, one-cycle frame start pulse.
- abort, in, 1, one-cycle frame abort pulse.
- src_data, in, 16, signed pixel.
- src_valid, in, 1, pixel present.
- src_ready, out, 1, controller accepts pixel.
- eng_data, out, 16, pixel to the engine.
- eng_row, out, 5, pixel position within the line, 0..IMG_W-1.
- eng_col, out, 2, line-buffer slot, line index mod 3.
- eng_rdata, out, 1, engine pixel strobe.
- eng_result, in, 32, engine convolution result.
- eng_fin, in, 1, engine result strobe.
- res_data, out, 32, forwarded result.
- res_valid, out, 1, result strobe.
- res_x, out, 5, result column, 0..IMG_W-3.
- res_y, out, 5, result line, 0..IMG_H-3.
- busy, out, 1, frame in progress.
- done, out, 1, one-cycle frame-complete pulse.
- err, out, 1, sticky drain-timeout flag.

Function
REQ-003 The FSM SHALL have states IDLE, FEED, DRAIN and FIN, with IDLE as the reset state.
REQ-004 In IDLE, start SHALL cause a move to FEED and clear all counters and the result coordinates; any start seen outside IDLE SHALL be ignored.
REQ-005 In FEED, src_ready SHALL be 1, and a pixel is accepted only on a cycle with src_valid=1 and src_ready=1.
REQ-006 On each accepted pixel the controller SHALL drive eng_data=src_data, eng_rdata=1, and eng_row/eng_col equal to the current position, registered so that all three appear in the next cycle.
REQ-007 On each accepted pixel, eng_row SHALL advance 0..IMG_W-1 and then wrap to 0; on that wrap, eng_col SHALL advance 0,1,2,0,...
REQ-008 A separate 5-bit line counter SHALL count 0..IMG_H-1.
REQ-009 Source stalls (src_valid=0) SHALL hold eng_row, eng_col and eng_data, and SHALL drive eng_rdata=0.
REQ-010 After pixel IMG_W*IMG_H (784 at default) is accepted, src_ready SHALL drop in the next cycle and the FSM SHALL enter DRAIN.
REQ-011 The expected result count per frame SHALL be (IMG_W-2)*(IMG_H-2), i.e. 676 at default, held in a 10-bit counter.
REQ-012 Each eng_fin=1 SHALL produce, one clock later:
- res_valid=1;
- res_data=eng_result;
- res_x/res_y set to the current coordinates, which then advance with res_x wrapping at IMG_W-3 and incrementing res_y.
REQ-013 eng_fin SHALL be honoured in FEED and DRAIN and ignored in IDLE and FIN.
REQ-014 When the result count reaches the expected count, the FSM SHALL move to FIN, and FIN SHALL pulse done for one cycle and return to IDLE.
REQ-015 In DRAIN, a clock counter SHALL count clocks since the last eng_fin; if it exceeds DRAIN_MAX, err SHALL be set and the FSM SHALL go to FIN.
REQ-016 Results beyond the expected count SHALL be dropped, with no res_valid.
REQ-017 abort in FEED or DRAIN SHALL return the FSM to IDLE next cycle, drop src_ready, and produce no done; abort in IDLE SHALL have no effect.
REQ-018 If abort and the final eng_fin occur in the same cycle, abort SHALL win.
REQ-019 If the last pixel is accepted in the same cycle as an eng_fin, both events SHALL be processed.
REQ-020 busy SHALL be 1 in FEED and DRAIN, and 0 otherwise.
REQ-021 err SHALL clear only on reset or on start.

Reset
REQ-022 Reset SHALL put the FSM in IDLE and set every output to zero, except eng_col which also resets to 0.
REQ-023 Reset mid-frame SHALL discard all state; the next frame requires a new start.

Configuration
REQ-024 With CONV_SCHED_PERF_EN defined, the block SHALL add two outputs:
- stall_cnt[15:0]: counts FEED cycles with src_valid=0, saturating at 16'hFFFF.
- frame_cycles[15:0]: counts clocks from start to done.
Both SHALL clear on start.
REQ-025 Without CONV_SCHED_PERF_EN, these ports and counters SHALL be absent, with identical behaviour otherwise.

Structure
REQ-026 A shared package conv_pkg SHALL hold:
- the FSM state enum;
- IMG_W/IMG_H defaults;
- the ENG_LAT default;
- widths of pixel (16) and result (32).
REQ-027 One sub-module, conv_pos_cnt, SHALL implement the row/slot/line position counter and SHALL be instantiated once for the input side; result coordinates SHALL be inline.

Verification
REQ-028 Start, then 784 back-to-back valid pixels, with the engine model returning eng_fin ENG_LAT clocks after each accepted pixel from line 2 onward -> exactly 676 res_valid, first at res_x=0/res_y=0, last at res_x=25/res_y=25, one done pulse, err=0.
REQ-029 src_valid toggled 1,0,1,0 throughout -> eng_rdata only on accepted pixels, eng_row/eng_col held during stalls, 676 results; with PERF_EN, stall_cnt=783.
REQ-030 Accept pixel 28 -> eng_row=0 and eng_col=1; accept pixel 84 -> eng_col=0 (wrap).
REQ-031 Abort after 300 pixels -> IDLE next cycle, src_ready=0, no done; a following start runs a clean full frame.
REQ-032 Engine model withholds the last 3 eng_fin -> after DRAIN_MAX+1 idle clocks, err=1, done pulses, 673 results seen.
REQ-033 Reset asserted mid-DRAIN -> all outputs 0 immediately, FSM in IDLE, and a subsequent start works.
